mix_sequencer: RTL

- Parametrised successor to the lane-mix/permute sequencer.
- Builds a per-lane mixed operand vector from `sel`/`b`/`c` and captures it with a valid/ready load handshake.
- Runs a programmable number of permute steps (mod-4 op cycle) over a LANES×LANE_W word, then presents the result with a valid/ready output handshake.
- Sits between the operand staging registers and the downstream consumer.

---
 rtl/mix_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mix_sequencer.sv
// Lane-mix/permute sequencer: loads a per-lane mixed operand, runs STEPS permute ops, presents result.
// Optional macro MIX_SEQ_HOLD_EN adds a `hold` input that freezes progress while running.
module mix_sequencer #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int STEPS  = 4
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*LANES-1:0]             sel,
  input  logic [LANES*LANE_W-1:0]        b,
  input  logic [LANES*LANE_W-1:0]        c,
  output logic [LANES*LANE_W-1:0]        out,
  output logic                           out_valid,
  input  logic                           out_ready,
`ifdef MIX_SEQ_HOLD_EN
  input  logic                           hold,
`endif
  output logic                           busy,
  output logic [$clog2(STEPS+1)-1:0]     step
);

  localparam int W      = LANES * LANE_W;
  localparam int H      = LANE_W / 2;
  localparam int HL     = (LANE_W - 2) / 2;
  localparam int STEP_W = $clog2(STEPS + 1);
  localparam int NIB    = W / 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [W-1:0]      m, m_n, out_n, mix, op_res, nib_rev;
  logic [STEP_W-1:0] step_n;
  logic              valid_n, run_hold;
  logic [1:0]        op_sel;
  logic [1:0]        sel_i;

`ifdef MIX_SEQ_HOLD_EN
  always_comb run_hold = hold;
`else
  always_comb run_hold = 1'b0;
`endif

  always_comb begin
    mix = '0;
    sel_i = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sel_i = sel[2*i +: 2];
      case (sel_i)
        2'd0:    mix[i*LANE_W +: LANE_W] = b[i*LANE_W +: LANE_W];
        2'd1:    mix[i*LANE_W +: LANE_W] = {b[i*LANE_W +: H], c[i*LANE_W+H +: H]};
        2'd2:    mix[i*LANE_W +: LANE_W] = c[i*LANE_W +: LANE_W];
        default: mix[i*LANE_W +: LANE_W] = {sel_i, c[i*LANE_W +: HL], b[i*LANE_W +: HL]};
      endcase
    end
  end

  always_comb begin
    nib_rev = '0;
    for (int unsigned i = 0; i < NIB; i++)
      nib_rev[i*4 +: 4] = out[(NIB-1-i)*4 +: 4];
  end

  // Op index is step mod 4; the cast zero-extends or truncates as STEP_W requires.
  always_comb begin
    op_sel = 2'(step);
    case (op_sel)
      2'd0:    op_res = {out[W-LANE_W-1:0], out[W-1:W-LANE_W]};
      2'd1:    op_res = {out[W-LANE_W-1:0], m[LANE_W-1:0]};
      2'd2:    op_res = {m[W-1:W-LANE_W], out[W-1:LANE_W]};
      default: op_res = nib_rev;
    endcase
  end

  always_comb begin
    state_n = state;
    out_n   = out;
    m_n     = m;
    step_n  = step;
    valid_n = out_valid;
    case (state)
      IDLE: if (in_valid) begin
        m_n     = mix;
        out_n   = mix;
        step_n  = '0;
        state_n = RUN;
      end
      RUN: if (!run_hold) begin
        out_n  = op_res;
        step_n = step + STEP_W'(1);
        if (step == STEP_W'(STEPS - 1)) begin
          state_n = DONE;
          valid_n = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      out       <= '0;
      m         <= '0;
      step      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      m         <= m_n;
      step      <= step_n;
      out_valid <= valid_n;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);

endmodule
